// File: rtl/multibyte_add_sequencer.sv
// multibyte_add_sequencer: wide add/sub by running one 8-bit lookahead slice LSB-first over NBYTES cycles
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                overflow
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [7:0] sa, sb, g, p, ss;
  logic [8:0] c;
  logic t, last;
  // each carry is expanded from the slice generate/propagate terms, not chained
  always_comb begin
    sa = a_q[8*cnt_q +: 8];
    sb = b_q[8*cnt_q +: 8] ^ {8{sub_q}};
    g = sa & sb;
    p = sa ^ sb;
    c[0] = carry_q;
    t = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t = carry_q;
      for (int j = 0; j <= i; j++) t = g[j] | (p[j] & t);
      c[i+1] = t;
    end
    ss = p ^ c[7:0];
    last = cnt_q == CW'(NBYTES - 1);
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sub_d = sub_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = a;
        b_d = b;
        sub_d = sub;
        carry_d = sub;
        cnt_d = '0;
        state_d = ADD;
      end
      ADD: begin
        sum_d[8*cnt_q +: 8] = ss;
        carry_d = c[8];
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cout_d = c[8];
          ovf_d = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (ss[7] != a_q[W-1]);
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      sum_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sub_q <= sub_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign overflow = ovf_q;
endmodule
